// File: rtl/encoder4_2_seq.sv
// Sequential 4-to-2 priority encoder: accumulates multi-hot requests and emits
// one encoded index per valid/ready transfer, highest bit first.
module encoder4_2_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] in,
  output logic [1:0] out,
  output logic       valid,
  input  logic       ready,
  output logic [3:0] pend,
  output logic       idle
);

  localparam int unsigned N     = 4;
  localparam int unsigned OUT_W = 2;

  logic [N-1:0]     cand;
  logic             load;
  logic [OUT_W-1:0] sel;
  logic [N-1:0]     sel_mask;

  // Candidate set, output-stage free flag and highest-priority pick
  always_comb begin
    cand     = pend | (en ? in : N'(0));
    load     = !valid || ready;
    sel      = OUT_W'(0);
    sel_mask = N'(0);
    casez (cand)
      4'b1???: sel = OUT_W'(3);
      4'b01??: sel = OUT_W'(2);
      4'b001?: sel = OUT_W'(1);
      default: sel = OUT_W'(0);
    endcase
    sel_mask = N'(1) << sel;
  end

  // Output stage and pending register; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out   <= OUT_W'(0);
      valid <= 1'b0;
      pend  <= N'(0);
    end else if (load) begin
      if (cand != N'(0)) begin
        out   <= sel;
        valid <= 1'b1;
        pend  <= cand & ~sel_mask;
      end else begin
        valid <= 1'b0;
        pend  <= N'(0);
      end
    end else begin
      pend <= cand;
    end
  end

  assign idle = !valid && (pend == N'(0));

endmodule

// File: tb/tb_encoder4_2_seq.sv
// Bench for encoder4_2_seq: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural request-set model.
module tb_encoder4_2_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] in;
  logic [1:0] out;
  logic       valid;
  logic       ready;
  logic [3:0] pend;
  logic       idle;

  int total = 0;
  int bad   = 0;

  encoder4_2_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .in    (in),
    .out   (out),
    .valid (valid),
    .ready (ready),
    .pend  (pend),
    .idle  (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: waiting requests kept as a set of flags, held index as an int
  bit m_req [4];
  int m_out   = 0;
  bit m_valid = 1'b0;

  function automatic int model_pend();
    int p = 0;
    for (int b = 0; b < 4; b++) if (m_req[b]) p += (1 << b);
    return p;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) m_req[b] = 1'b0;
      m_out   = 0;
      m_valid = 1'b0;
    end else begin
      bit consumer_free;
      int pick;
      consumer_free = !m_valid || ready;
      if (en) for (int b = 0; b < 4; b++) if (in[b]) m_req[b] = 1'b1;
      if (consumer_free) begin
        pick = -1;
        for (int b = 3; b >= 0; b--) if (pick < 0 && m_req[b]) pick = b;
        if (pick >= 0) begin
          m_out       = pick;
          m_valid     = 1'b1;
          m_req[pick] = 1'b0;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  bit checking = 1'b0;
  always @(negedge clk) begin
    if (checking) begin
      chk("model.out",   int'(out),   m_out);
      chk("model.valid", int'(valid), int'(m_valid));
      chk("model.pend",  int'(pend),  model_pend());
      chk("model.idle",  int'(idle),  int'(!m_valid && model_pend() == 0));
    end
  end

  // Apply inputs, let one rising edge consume them, return just after the next negedge
  task automatic drive(input logic r, input logic e, input logic [3:0] i, input logic rd);
    rst_n = r;
    en    = e;
    in    = i;
    ready = rd;
    @(negedge clk);
    #1;
  endtask

  task automatic expect3(input string name, input int o, input int v, input int p);
    chk({name, ".out"},   int'(out),   o);
    chk({name, ".valid"}, int'(valid), v);
    chk({name, ".pend"},  int'(pend),  p);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    in    = 4'b1111;
    ready = 1'b1;
    checking = 1'b1;

    // Reset with requests present
    drive(1'b0, 1'b1, 4'b1111, 1'b1);
    drive(1'b0, 1'b1, 4'b1111, 1'b1);
    expect3("reset", 0, 0, 0);
    chk("reset.idle", int'(idle), 1);

    // Single request, one-cycle latency
    drive(1'b1, 1'b1, 4'b0100, 1'b1);
    expect3("single", 2, 1, 0);
    drive(1'b1, 1'b1, 4'b0000, 1'b1);
    chk("single.drained", int'(valid), 0);
    chk("single.idle", int'(idle), 1);

    // Multi-hot drain, no bubbles
    drive(1'b1, 1'b1, 4'b1011, 1'b1);
    expect3("drain0", 3, 1, 4'b0011);
    drive(1'b1, 1'b1, 4'b0000, 1'b1);
    expect3("drain1", 1, 1, 4'b0001);
    drive(1'b1, 1'b1, 4'b0000, 1'b1);
    expect3("drain2", 0, 1, 0);
    drive(1'b1, 1'b1, 4'b0000, 1'b1);
    chk("drain.end", int'(valid), 0);

    // Backpressure holds the output stage
    drive(1'b1, 1'b1, 4'b0011, 1'b0);
    expect3("stall0", 1, 1, 4'b0001);
    drive(1'b1, 1'b1, 4'b0000, 1'b0);
    expect3("stall1", 1, 1, 4'b0001);
    drive(1'b1, 1'b1, 4'b0000, 1'b0);
    expect3("stall2", 1, 1, 4'b0001);
    drive(1'b1, 1'b1, 4'b0000, 1'b1);
    expect3("release", 0, 1, 0);
    drive(1'b1, 1'b1, 4'b0000, 1'b1);
    chk("release.end", int'(valid), 0);

    // Enable gating, then reset mid-transfer
    drive(1'b1, 1'b0, 4'b1111, 1'b1);
    drive(1'b1, 1'b0, 4'b1111, 1'b1);
    expect3("gated", 0, 0, 0);
    drive(1'b1, 1'b1, 4'b1100, 1'b0);
    expect3("pre_rst", 3, 1, 4'b0100);
    drive(1'b0, 1'b1, 4'b1100, 1'b0);
    expect3("mid_rst", 0, 0, 0);

    // Re-request of the held bit is emitted again
    drive(1'b1, 1'b1, 4'b1000, 1'b0);
    expect3("rereq0", 3, 1, 0);
    drive(1'b1, 1'b1, 4'b1000, 1'b0);
    expect3("rereq1", 3, 1, 4'b1000);
    drive(1'b1, 1'b0, 4'b0000, 1'b1);
    expect3("rereq2", 3, 1, 0);
    drive(1'b1, 1'b0, 4'b0000, 1'b1);
    chk("rereq.end", int'(valid), 0);

    // Randomized traffic, checked by the per-cycle compare
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15) & $urandom_range(0, 15)),
            ($urandom_range(0, 2) != 0));
    end

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
